// File: rtl/des_pkg.sv
// Shared DES constants: permutation tables, S-boxes, key-shift schedule, FSM states and
// the bit-permutation helpers used by the core and its round function.
package des_pkg;

  localparam int unsigned Rounds = 16;

  typedef enum logic [1:0] {StIdle, StRound, StDone} des_state_e;

  // Table entries use DES numbering: bit 1 is the MSB of the vector.
  localparam int unsigned IpTab [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7
  };

  localparam int unsigned FpTab [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25
  };

  localparam int unsigned ETab [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9, 10, 11,
    12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
    22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
  };

  localparam int unsigned PTab [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
  };

  localparam int unsigned Pc1Tab [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned Pc2Tab [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  localparam logic [1:0] ShiftTab [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // Each box is stored row-major: index = row * 16 + column.
  localparam logic [3:0] SboxTab [8][64] = '{
    '{4'd14, 4'd4, 4'd13, 4'd1, 4'd2, 4'd15, 4'd11, 4'd8, 4'd3, 4'd10, 4'd6, 4'd12, 4'd5, 4'd9, 4'd0, 4'd7,
      4'd0, 4'd15, 4'd7, 4'd4, 4'd14, 4'd2, 4'd13, 4'd1, 4'd10, 4'd6, 4'd12, 4'd11, 4'd9, 4'd5, 4'd3, 4'd8,
      4'd4, 4'd1, 4'd14, 4'd8, 4'd13, 4'd6, 4'd2, 4'd11, 4'd15, 4'd12, 4'd9, 4'd7, 4'd3, 4'd10, 4'd5, 4'd0,
      4'd15, 4'd12, 4'd8, 4'd2, 4'd4, 4'd9, 4'd1, 4'd7, 4'd5, 4'd11, 4'd3, 4'd14, 4'd10, 4'd0, 4'd6, 4'd13},
    '{4'd15, 4'd1, 4'd8, 4'd14, 4'd6, 4'd11, 4'd3, 4'd4, 4'd9, 4'd7, 4'd2, 4'd13, 4'd12, 4'd0, 4'd5, 4'd10,
      4'd3, 4'd13, 4'd4, 4'd7, 4'd15, 4'd2, 4'd8, 4'd14, 4'd12, 4'd0, 4'd1, 4'd10, 4'd6, 4'd9, 4'd11, 4'd5,
      4'd0, 4'd14, 4'd7, 4'd11, 4'd10, 4'd4, 4'd13, 4'd1, 4'd5, 4'd8, 4'd12, 4'd6, 4'd9, 4'd3, 4'd2, 4'd15,
      4'd13, 4'd8, 4'd10, 4'd1, 4'd3, 4'd15, 4'd4, 4'd2, 4'd11, 4'd6, 4'd7, 4'd12, 4'd0, 4'd5, 4'd14, 4'd9},
    '{4'd10, 4'd0, 4'd9, 4'd14, 4'd6, 4'd3, 4'd15, 4'd5, 4'd1, 4'd13, 4'd12, 4'd7, 4'd11, 4'd4, 4'd2, 4'd8,
      4'd13, 4'd7, 4'd0, 4'd9, 4'd3, 4'd4, 4'd6, 4'd10, 4'd2, 4'd8, 4'd5, 4'd14, 4'd12, 4'd11, 4'd15, 4'd1,
      4'd13, 4'd6, 4'd4, 4'd9, 4'd8, 4'd15, 4'd3, 4'd0, 4'd11, 4'd1, 4'd2, 4'd12, 4'd5, 4'd10, 4'd14, 4'd7,
      4'd1, 4'd10, 4'd13, 4'd0, 4'd6, 4'd9, 4'd8, 4'd7, 4'd4, 4'd15, 4'd14, 4'd3, 4'd11, 4'd5, 4'd2, 4'd12},
    '{4'd7, 4'd13, 4'd14, 4'd3, 4'd0, 4'd6, 4'd9, 4'd10, 4'd1, 4'd2, 4'd8, 4'd5, 4'd11, 4'd12, 4'd4, 4'd15,
      4'd13, 4'd8, 4'd11, 4'd5, 4'd6, 4'd15, 4'd0, 4'd3, 4'd4, 4'd7, 4'd2, 4'd12, 4'd1, 4'd10, 4'd14, 4'd9,
      4'd10, 4'd6, 4'd9, 4'd0, 4'd12, 4'd11, 4'd7, 4'd13, 4'd15, 4'd1, 4'd3, 4'd14, 4'd5, 4'd2, 4'd8, 4'd4,
      4'd3, 4'd15, 4'd0, 4'd6, 4'd10, 4'd1, 4'd13, 4'd8, 4'd9, 4'd4, 4'd5, 4'd11, 4'd12, 4'd7, 4'd2, 4'd14},
    '{4'd2, 4'd12, 4'd4, 4'd1, 4'd7, 4'd10, 4'd11, 4'd6, 4'd8, 4'd5, 4'd3, 4'd15, 4'd13, 4'd0, 4'd14, 4'd9,
      4'd14, 4'd11, 4'd2, 4'd12, 4'd4, 4'd7, 4'd13, 4'd1, 4'd5, 4'd0, 4'd15, 4'd10, 4'd3, 4'd9, 4'd8, 4'd6,
      4'd4, 4'd2, 4'd1, 4'd11, 4'd10, 4'd13, 4'd7, 4'd8, 4'd15, 4'd9, 4'd12, 4'd5, 4'd6, 4'd3, 4'd0, 4'd14,
      4'd11, 4'd8, 4'd12, 4'd7, 4'd1, 4'd14, 4'd2, 4'd13, 4'd6, 4'd15, 4'd0, 4'd9, 4'd10, 4'd4, 4'd5, 4'd3},
    '{4'd12, 4'd1, 4'd10, 4'd15, 4'd9, 4'd2, 4'd6, 4'd8, 4'd0, 4'd13, 4'd3, 4'd4, 4'd14, 4'd7, 4'd5, 4'd11,
      4'd10, 4'd15, 4'd4, 4'd2, 4'd7, 4'd12, 4'd9, 4'd5, 4'd6, 4'd1, 4'd13, 4'd14, 4'd0, 4'd11, 4'd3, 4'd8,
      4'd9, 4'd14, 4'd15, 4'd5, 4'd2, 4'd8, 4'd12, 4'd3, 4'd7, 4'd0, 4'd4, 4'd10, 4'd1, 4'd13, 4'd11, 4'd6,
      4'd4, 4'd3, 4'd2, 4'd12, 4'd9, 4'd5, 4'd15, 4'd10, 4'd11, 4'd14, 4'd1, 4'd7, 4'd6, 4'd0, 4'd8, 4'd13},
    '{4'd4, 4'd11, 4'd2, 4'd14, 4'd15, 4'd0, 4'd8, 4'd13, 4'd3, 4'd12, 4'd9, 4'd7, 4'd5, 4'd10, 4'd6, 4'd1,
      4'd13, 4'd0, 4'd11, 4'd7, 4'd4, 4'd9, 4'd1, 4'd10, 4'd14, 4'd3, 4'd5, 4'd12, 4'd2, 4'd15, 4'd8, 4'd6,
      4'd1, 4'd4, 4'd11, 4'd13, 4'd12, 4'd3, 4'd7, 4'd14, 4'd10, 4'd15, 4'd6, 4'd8, 4'd0, 4'd5, 4'd9, 4'd2,
      4'd6, 4'd11, 4'd13, 4'd8, 4'd1, 4'd4, 4'd10, 4'd7, 4'd9, 4'd5, 4'd0, 4'd15, 4'd14, 4'd2, 4'd3, 4'd12},
    '{4'd13, 4'd2, 4'd8, 4'd4, 4'd6, 4'd15, 4'd11, 4'd1, 4'd10, 4'd9, 4'd3, 4'd14, 4'd5, 4'd0, 4'd12, 4'd7,
      4'd1, 4'd15, 4'd13, 4'd8, 4'd10, 4'd3, 4'd7, 4'd4, 4'd12, 4'd5, 4'd6, 4'd11, 4'd0, 4'd14, 4'd9, 4'd2,
      4'd7, 4'd11, 4'd4, 4'd1, 4'd9, 4'd12, 4'd14, 4'd2, 4'd0, 4'd6, 4'd10, 4'd13, 4'd15, 4'd3, 4'd5, 4'd8,
      4'd2, 4'd1, 4'd14, 4'd7, 4'd4, 4'd10, 4'd8, 4'd13, 4'd15, 4'd12, 4'd9, 4'd0, 4'd3, 4'd5, 4'd6, 4'd11}
  };

  function automatic logic [63:0] des_ip(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IpTab[i])];
    return y;
  endfunction

  function automatic logic [63:0] des_fp(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FpTab[i])];
    return y;
  endfunction

  function automatic logic [47:0] des_e(input logic [31:0] x);
    logic [47:0] y;
    y = '0;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - ETab[i])];
    return y;
  endfunction

  function automatic logic [31:0] des_p(input logic [31:0] x);
    logic [31:0] y;
    y = '0;
    for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - PTab[i])];
    return y;
  endfunction

  // Parity bits 8, 16, ..., 64 never appear in the table, so they drop out here.
  function automatic logic [55:0] des_pc1(input logic [63:0] x);
    logic [55:0] y;
    y = '0;
    for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - Pc1Tab[i])];
    return y;
  endfunction

  function automatic logic [47:0] des_pc2(input logic [55:0] x);
    logic [47:0] y;
    y = '0;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - Pc2Tab[i])];
    return y;
  endfunction

  // Row comes from the outer bits, column from the inner four.
  function automatic logic [3:0] des_sbox(input logic [2:0] n, input logic [5:0] b);
    return SboxTab[n][{b[5], b[0], b[4:1]}];
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
    return (n == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
    return (n == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

endpackage

// File: rtl/des_round_f.sv
// DES Feistel function f(R, K): expansion, key mix, eight S-boxes and the P permutation.
module des_round_f
  import des_pkg::*;
(
  input  logic [31:0] r,
  input  logic [47:0] k,
  output logic [31:0] f
);

  logic [47:0] mixed;
  logic [31:0] sbox_out;

  assign mixed = des_e(r) ^ k;

  for (genvar g = 0; g < 8; g++) begin : g_sbox
    assign sbox_out[31 - 4 * g -: 4] = des_sbox(3'(g), mixed[47 - 6 * g -: 6]);
  end

  assign f = des_p(sbox_out);

endmodule

// File: rtl/des_core.sv
// Iterative DES engine: one Feistel round per clock, 16 rounds per block, with an
// on-the-fly key schedule that rotates left for encryption and right for decryption.
module des_core
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        des_encipher_en,
  input  logic        des_decipher_en,
  input  logic [63:0] des_data,
  input  logic [63:0] des_key_in,
  output logic        desc_ready,
  output logic [63:0] desc_result
);

  des_state_e  state_q, state_d;
  logic [3:0]  round_q, round_d;
  logic [31:0] l_q, l_d, r_q, r_d;
  logic [27:0] key_c_q, key_c_d, key_d_q, key_d_d;
  logic        decrypt_q, decrypt_d;
  logic        ready_q, ready_d;
  logic [63:0] result_q, result_d;

  logic [3:0]  dec_idx;
  logic [27:0] c_rot, d_rot;
  logic [47:0] subkey;
  logic [31:0] f_out;
  logic [63:0] ip_blk;
  logic [55:0] pc1_key;

  // Decrypt walks the schedule backwards: round i > 1 undoes SHIFT[18 - i].
  always_comb begin
    dec_idx = 4'(5'd16 - {1'b0, round_q});
    c_rot   = key_c_q;
    d_rot   = key_d_q;
    if (!decrypt_q) begin
      c_rot = rotl28(key_c_q, ShiftTab[round_q]);
      d_rot = rotl28(key_d_q, ShiftTab[round_q]);
    end else if (round_q != 4'd0) begin
      c_rot = rotr28(key_c_q, ShiftTab[dec_idx]);
      d_rot = rotr28(key_d_q, ShiftTab[dec_idx]);
    end
    subkey = des_pc2({c_rot, d_rot});
  end

  des_round_f u_round_f (
    .r (r_q),
    .k (subkey),
    .f (f_out)
  );

  assign ip_blk  = des_ip(des_data);
  assign pc1_key = des_pc1(des_key_in);

  always_comb begin
    state_d   = state_q;
    round_d   = round_q;
    l_d       = l_q;
    r_d       = r_q;
    key_c_d   = key_c_q;
    key_d_d   = key_d_q;
    decrypt_d = decrypt_q;
    ready_d   = 1'b0;
    result_d  = result_q;

    unique case (state_q)
      StIdle: begin
        if (des_encipher_en || des_decipher_en) begin
          decrypt_d = ~des_encipher_en;
          l_d       = ip_blk[63:32];
          r_d       = ip_blk[31:0];
          key_c_d   = pc1_key[55:28];
          key_d_d   = pc1_key[27:0];
          round_d   = 4'd0;
          state_d   = StRound;
        end
      end
      StRound: begin
        l_d     = r_q;
        r_d     = l_q ^ f_out;
        key_c_d = c_rot;
        key_d_d = d_rot;
        round_d = round_q + 4'd1;
        if (round_q == 4'(Rounds - 1)) begin
          // Output is R16 || L16: the last round's swap is undone before FP.
          result_d = des_fp({l_q ^ f_out, r_q});
          ready_d  = 1'b1;
          state_d  = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      round_q   <= 4'd0;
      l_q       <= '0;
      r_q       <= '0;
      key_c_q   <= '0;
      key_d_q   <= '0;
      decrypt_q <= 1'b0;
      ready_q   <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      round_q   <= round_d;
      l_q       <= l_d;
      r_q       <= r_d;
      key_c_q   <= key_c_d;
      key_d_q   <= key_d_d;
      decrypt_q <= decrypt_d;
      ready_q   <= ready_d;
      result_q  <= result_d;
    end
  end

  assign desc_ready  = ready_q;
  assign desc_result = result_q;

endmodule

// File: tb/tb_des_core.sv
// Self-checking bench for des_core: FIPS known answers, latency and strobe behaviour,
// reset mid-operation, and random blocks against a loop-based DES reference model.
module tb_des_core;
  import des_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        des_encipher_en;
  logic        des_decipher_en;
  logic [63:0] des_data;
  logic [63:0] des_key_in;
  logic        desc_ready;
  logic [63:0] desc_result;

  int vectors;
  int miscompares;
  int pulses;

  des_core dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .des_encipher_en (des_encipher_en),
    .des_decipher_en (des_decipher_en),
    .des_data        (des_data),
    .des_key_in      (des_key_in),
    .desc_ready      (desc_ready),
    .desc_result     (desc_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (rst_n && desc_ready) pulses++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: bit-serial permutations and a precomputed subkey array.
  function automatic logic [63:0] m_perm64(input logic [63:0] x, input bit final_p);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++)
      y = (y << 1) | 64'((x >> (64 - (final_p ? FpTab[i] : IpTab[i]))) & 64'd1);
    return y;
  endfunction

  function automatic logic [31:0] m_f(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s;
    logic [31:0] p;
    logic [5:0]  six;
    x = '0;
    for (int i = 0; i < 48; i++) x = (x << 1) | 48'((r >> (32 - ETab[i])) & 32'd1);
    x = x ^ k;
    s = '0;
    for (int j = 0; j < 8; j++) begin
      six = 6'(x >> (42 - 6 * j));
      s = (s << 4) | 32'(SboxTab[j][32'({six[5], six[0]}) * 16 + 32'(six[4:1])]);
    end
    p = '0;
    for (int i = 0; i < 32; i++) p = (p << 1) | ((s >> (32 - PTab[i])) & 32'd1);
    return p;
  endfunction

  function automatic logic [63:0] des_model(input logic [63:0] data, input logic [63:0] key,
                                            input bit decrypt);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] ks [16];
    logic [63:0] lr;
    logic [31:0] l, r, t;
    int          sh;
    cd = '0;
    for (int i = 0; i < 56; i++) cd = (cd << 1) | 56'((key >> (64 - Pc1Tab[i])) & 64'd1);
    c = cd[55:28];
    d = cd[27:0];
    for (int i = 0; i < 16; i++) begin
      sh = int'(ShiftTab[i]);
      c = (c << sh) | (c >> (28 - sh));
      d = (d << sh) | (d >> (28 - sh));
      ks[i] = '0;
      for (int b = 0; b < 48; b++)
        ks[i] = (ks[i] << 1) | 48'(({c, d} >> (56 - Pc2Tab[b])) & 56'd1);
    end
    lr = m_perm64(data, 1'b0);
    l = lr[63:32];
    r = lr[31:0];
    for (int i = 0; i < 16; i++) begin
      t = r;
      r = l ^ m_f(r, decrypt ? ks[15 - i] : ks[i]);
      l = t;
    end
    return m_perm64({r, l}, 1'b1);
  endfunction

  // Runs one operation; optionally disturbs inputs mid-round. Checks latency and strobe.
  task automatic do_op(input string tag, input logic [63:0] data, input logic [63:0] key,
                       input bit enc, input bit dec, input int hold, input bit disturb,
                       output logic [63:0] res);
    int lat;
    res = '0;
    lat = 0;
    @(negedge clk);
    des_data        = data;
    des_key_in      = key;
    des_encipher_en = enc;
    des_decipher_en = dec;
    pulses          = 0;
    @(posedge clk);
    #1;
    if (hold <= 1) begin des_encipher_en = 1'b0; des_decipher_en = 1'b0; end
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (disturb && n >= 4 && n < 7) begin
        des_encipher_en = 1'b1;
        des_decipher_en = 1'b1;
        des_data        = {$urandom, $urandom};
        des_key_in      = {$urandom, $urandom};
      end else if (n + 1 >= hold) begin
        des_encipher_en = 1'b0;
        des_decipher_en = 1'b0;
      end
      if (desc_ready) begin
        lat = n;
        res = desc_result;
        break;
      end
    end
    check({tag, "_latency"}, 64'(lat), 64'd16);
    @(posedge clk);
    #1;
    check({tag, "_ready_drop"}, 64'(desc_ready), 64'd0);
    check({tag, "_result_hold"}, desc_result, res);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_pulses"}, 64'(pulses), 64'd1);
  endtask

  localparam logic [63:0] Key1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] Key3 = 64'h0E329232EA6D0D73;
  localparam logic [63:0] Key4 = 64'h0133457799BBCDFF;

  initial begin
    logic [63:0] res, res2, data, key;
    int          mode;
    vectors         = 0;
    miscompares     = 0;
    pulses          = 0;
    rst_n           = 1'b0;
    des_encipher_en = 1'b0;
    des_decipher_en = 1'b0;
    des_data        = '0;
    des_key_in      = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 64'(desc_ready), 64'd0);
    check("reset_result", desc_result, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("t1", 64'h0123456789ABCDEF, Key1, 1'b1, 1'b0, 1, 1'b0, res);
    check("t1_result", res, 64'h85E813540F0AB405);

    do_op("t2", 64'h85E813540F0AB405, Key1, 1'b0, 1'b1, 2, 1'b0, res);
    check("t2_result", res, 64'h0123456789ABCDEF);

    do_op("t3", 64'h8787878787878787, Key3, 1'b1, 1'b0, 1, 1'b0, res);
    check("t3_result", res, 64'h0);
    do_op("t3p", 64'h8787878787878787, Key3 ^ 64'h0101010101010101, 1'b1, 1'b0, 1, 1'b0, res);
    check("t3p_result", res, 64'h0);

    do_op("t4e", 64'h00123456789ABCDE, Key4, 1'b1, 1'b0, 1, 1'b0, res);
    check("t4e_model", res, des_model(64'h00123456789ABCDE, Key4, 1'b0));
    do_op("t4d", res, Key4, 1'b0, 1'b1, 1, 1'b0, res2);
    check("t4d_roundtrip", res2, 64'h00123456789ABCDE);
    do_op("t4d2", 64'h1ABFF69D5A93E80B, Key4, 1'b0, 1'b1, 1, 1'b0, res);
    check("t4d2_model", res, des_model(64'h1ABFF69D5A93E80B, Key4, 1'b1));
    do_op("t4e2", res, Key4, 1'b1, 1'b0, 1, 1'b0, res2);
    check("t4e2_roundtrip", res2, 64'h1ABFF69D5A93E80B);

    do_op("t5both", 64'h0123456789ABCDEF, Key1, 1'b1, 1'b1, 1, 1'b0, res);
    check("t5both_result", res, 64'h85E813540F0AB405);
    do_op("t5dist", 64'h8787878787878787, Key3, 1'b1, 1'b0, 1, 1'b1, res);
    check("t5dist_result", res, 64'h0);

    // Reset at round 8; the previous result is non-zero so clearing is observable.
    do_op("t6pre", 64'h0123456789ABCDEF, Key1, 1'b1, 1'b0, 1, 1'b0, res);
    @(negedge clk);
    des_data        = 64'h0123456789ABCDEF;
    des_key_in      = Key1;
    des_encipher_en = 1'b1;
    @(posedge clk);
    #1;
    des_encipher_en = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_ready", 64'(desc_ready), 64'd0);
    check("t6_rst_result", desc_result, 64'h0);
    pulses = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("t6_no_partial", 64'(pulses), 64'd0);
    do_op("t6post", 64'h0123456789ABCDEF, Key1, 1'b1, 1'b0, 1, 1'b0, res);
    check("t6post_result", res, 64'h85E813540F0AB405);

    for (int it = 0; it < 24; it++) begin
      data = {$urandom, $urandom};
      key  = {$urandom, $urandom};
      mode = int'($urandom_range(0, 2));
      do_op("rnd", data, key, mode != 1, mode != 0, int'($urandom_range(1, 3)), 1'b0, res);
      check("rnd_result", res, des_model(data, key, mode == 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
